// File: rtl/imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: state encoding and protocol bytes.
package imem_loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_COUNT, S_DATA_HI, S_DATA_LO, S_CSUM, S_RESP
    } state_t;

    localparam logic [7:0] LOAD_HDR = 8'hA5;
    localparam logic [7:0] LOAD_ACK = 8'h06;
    localparam logic [7:0] LOAD_NAK = 8'h15;
endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled, flags expiry on the last allowed cycle.
module imem_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = enable && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear || !enable)
            count <= '0;
        else if (!expired)
            count <= count + CW'(1);
    end
endmodule

// File: rtl/imem_loader.sv
// Parses framed UART load commands into instruction-memory writes and answers ACK/NAK.
// Define IMEM_LOADER_CHECKSUM_EN to require and check a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [15:0]       imem_wdata,
    output logic [7:0]        ack_data,
    output logic              ack_valid,
    input  logic              ack_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);
    state_t            state;
    logic [7:0]        addr_hi_q;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        remaining;
    logic [7:0]        data_hi_q;
    logic              expired;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    imem_loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (rx_valid),
        .enable  ((state != S_IDLE) && (state != S_RESP)),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            addr_hi_q  <= '0;
            addr       <= '0;
            remaining  <= '0;
            data_hi_q  <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            ack_data   <= '0;
            ack_valid  <= 1'b0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            // Accumulate every byte between the header and the checksum byte.
            if (rx_valid && state inside {S_ADDR_HI, S_ADDR_LO, S_COUNT, S_DATA_HI, S_DATA_LO})
                csum <= csum ^ rx_data;
`endif
            if (expired) begin
                state     <= S_RESP;
                ack_valid <= 1'b1;
                ack_data  <= LOAD_NAK;
                load_err  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (rx_valid && rx_data == LOAD_HDR) begin
                        state    <= S_ADDR_HI;
                        cpu_hold <= 1'b1;
                        load_err <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                    S_ADDR_HI: if (rx_valid) begin
                        addr_hi_q <= rx_data;
                        state     <= S_ADDR_LO;
                    end
                    S_ADDR_LO: if (rx_valid) begin
                        addr  <= ADDR_W'({addr_hi_q, rx_data});
                        state <= S_COUNT;
                    end
                    S_COUNT: if (rx_valid) begin
                        remaining <= rx_data;
                        if (rx_data != 8'd0)
                            state <= S_DATA_HI;
                        else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state     <= S_CSUM;
`else
                            state     <= S_RESP;
                            ack_valid <= 1'b1;
                            ack_data  <= LOAD_ACK;
`endif
                        end
                    end
                    S_DATA_HI: if (rx_valid) begin
                        data_hi_q <= rx_data;
                        state     <= S_DATA_LO;
                    end
                    S_DATA_LO: if (rx_valid) begin
                        imem_we    <= 1'b1;
                        imem_waddr <= addr;
                        imem_wdata <= {data_hi_q, rx_data};
                        addr       <= addr + ADDR_W'(1);
                        remaining  <= remaining - 8'd1;
                        if (remaining != 8'd1)
                            state <= S_DATA_HI;
                        else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state     <= S_CSUM;
`else
                            state     <= S_RESP;
                            ack_valid <= 1'b1;
                            ack_data  <= LOAD_ACK;
`endif
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CSUM: if (rx_valid) begin
                        state     <= S_RESP;
                        ack_valid <= 1'b1;
                        if (rx_data == csum)
                            ack_data <= LOAD_ACK;
                        else begin
                            ack_data <= LOAD_NAK;
                            load_err <= 1'b1;
                        end
                    end
`endif
                    // Bytes arriving while the response is pending are dropped.
                    S_RESP: if (ack_ready) begin
                        ack_valid <= 1'b0;
                        state     <= S_IDLE;
                        if (ack_data == LOAD_ACK) begin
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random frames against a frame-level model.
module tb_imem_loader;
    localparam int ADDR_W  = 12;
    localparam int TMO     = 40;
    localparam logic [7:0] HDR = 8'hA5, ACK = 8'h06, NAK = 8'h15;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [15:0]       d;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [15:0]       imem_wdata;
    logic [7:0]        ack_data;
    logic              ack_valid;
    logic              ack_ready = 1'b0;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    int vectors = 0;
    int miscompares = 0;
    wr_t exp_w[$];
    wr_t obs_w[$];
    logic [15:0] wq[$];

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .ack_data(ack_data), .ack_valid(ack_valid), .ack_ready(ack_ready),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) obs_w.push_back('{a: imem_waddr, d: imem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwr"}, obs_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            check({tag, "_waddr"}, 32'(obs_w[i].a), 32'(exp_w[i].a));
            check({tag, "_wdata"}, 32'(obs_w[i].d), 32'(exp_w[i].d));
        end
        exp_w.delete();
        obs_w.delete();
    endtask

    // Waits (bounded) for a response, optionally back-pressures it, then completes the handshake.
    task automatic wait_ack(input logic [7:0] expb, input string tag, input int hold, output int lat);
        logic [7:0] first;
        lat = 0;
        while (!ack_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_ackv"}, 32'(ack_valid), 32'd1);
        if (ack_valid) begin
            check({tag, "_ackd"}, 32'(ack_data), 32'(expb));
            first = ack_data;
            for (int i = 0; i < hold; i++) begin
                rx_data  = (i % 2 == 0) ? HDR : 8'h00;
                rx_valid = (i % 3 != 2);
                @(negedge clk);
                check({tag, "_hold_v"}, 32'(ack_valid), 32'd1);
                check({tag, "_hold_d"}, 32'(ack_data), 32'(first));
            end
            rx_valid  = 1'b0;
            ack_ready = 1'b1;
            @(negedge clk);
            ack_ready = 1'b0;
            check({tag, "_ackv_low"}, 32'(ack_valid), 32'd0);
            check({tag, "_done"}, 32'(load_done), 32'(expb == ACK));
            check({tag, "_hold"}, 32'(cpu_hold), 32'(expb != ACK));
            check({tag, "_err"}, 32'(load_err), 32'(expb == NAK));
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(load_done), 32'd0);
        end
    endtask

    // Sends a full frame of words in wq and records the writes and response the protocol requires.
    task automatic send_frame(input logic [15:0] start, input bit bad_csum, input int hold, input string tag);
        logic [7:0] bytes[$];
        logic [7:0] x;
        logic [7:0] expb;
        int lat;
        bytes = '{HDR, start[15:8], start[7:0], 8'(wq.size())};
        foreach (wq[i]) begin
            bytes.push_back(wq[i][15:8]);
            bytes.push_back(wq[i][7:0]);
            exp_w.push_back('{a: ADDR_W'((int'(start) + i) % (1 << ADDR_W)), d: wq[i]});
        end
        x = 8'h00;
        for (int i = 1; i < bytes.size(); i++) x ^= bytes[i];
        if (CSUM_EN) bytes.push_back(bad_csum ? ~x : x);
        expb = (CSUM_EN && bad_csum) ? NAK : ACK;
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_ack(expb, tag, hold, lat);
        compare_writes(tag);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_waddr", 32'(imem_waddr), 32'd0);
        check("rst_wdata", 32'(imem_wdata), 32'd0);
        check("rst_ackv", 32'(ack_valid), 32'd0);
        check("rst_ackd", 32'(ack_data), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        reset = 1'b1;

        wq = '{16'h0D00, 16'h0D11};
        send_frame(16'h0064, 1'b0, 0, "ack_frame");
        if (CSUM_EN) begin
            wq = '{16'h0D00, 16'h0D11};
            send_frame(16'h0064, 1'b1, 0, "nak_csum");
        end
        wq = '{16'h1111, 16'h2222};
        send_frame(16'h0FFF, 1'b0, 0, "wrap");

        // Silence mid-frame must time out with a NAK and no writes.
        send_byte(HDR); send_byte(8'h00); send_byte(8'h64); send_byte(8'h02); send_byte(8'h0D);
        wait_ack(NAK, "timeout", 0, lat);
        check("timeout_lat", 32'(lat), 32'(TMO));
        compare_writes("timeout");
        send_byte(HDR);
        check("err_cleared", 32'(load_err), 32'd0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        if (CSUM_EN) send_byte(8'h00);
        wait_ack(ACK, "count0", 0, lat);
        compare_writes("count0");

        // Reset mid-frame, then garbage in IDLE must be ignored.
        send_byte(HDR); send_byte(8'h00);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        check("midrst_ackv", 32'(ack_valid), 32'd0);
        send_byte(8'h00); send_byte(8'hFF);
        repeat (TMO + 10) @(negedge clk);
        check("garbage_ackv", 32'(ack_valid), 32'd0);
        compare_writes("garbage");

        wq = '{16'hBEEF};
        send_frame(16'h0123, 1'b0, 10, "backpressure");

        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(0, 5);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
            send_frame(16'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
